// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared types and widths for the whack-a-mole game blocks
package whack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam int LEVEL_W = 2;
  localparam int SPEED_W = 28;
  localparam int SCORE_W = 8;

endpackage

// File: rtl/second_tick.sv
// rtl/second_tick.sv - one-second prescaler producing a single-cycle tick
module second_tick
  import whack_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [SPEED_W-1:0] LAST = SPEED_W'(CLK_HZ - 1);

  logic [SPEED_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (!enable || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/level_controller.sv
// rtl/level_controller.sv - round timer, difficulty level and speed selection
module level_controller
  import whack_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int ROUND_SECONDS = 60,
  parameter int LVL1_SCORE    = 10,
  parameter int LVL2_SCORE    = 20,
  parameter int LVL3_SCORE    = 30
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [SCORE_W-1:0] score,
  output logic               game,
  output logic [SPEED_W-1:0] speed,
  output logic [LEVEL_W-1:0] level,
  output logic [7:0]         time_left,
  output logic               game_over
);

  localparam logic [7:0]         ROUND_T = 8'(ROUND_SECONDS);
  localparam logic [SPEED_W-1:0] SPD0    = SPEED_W'(CLK_HZ);
  localparam logic [SPEED_W-1:0] SPD1    = SPEED_W'(CLK_HZ * 3 / 4);
  localparam logic [SPEED_W-1:0] SPD2    = SPEED_W'(CLK_HZ / 2);
  localparam logic [SPEED_W-1:0] SPD3    = SPEED_W'(CLK_HZ / 4);

  state_t             state_q, state_d;
  logic               start_q;
  logic               arm_q, arm_d;
  logic [LEVEL_W-1:0] level_q, level_d, target;
  logic [7:0]         time_q, time_d;
  logic               start_edge;
  logic               tick;

  second_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .enable (state_q == ST_PLAY),
    .tick   (tick)
  );

  // arm_q stays low until start has been seen low after reset, so a button
  // held through reset cannot launch a round.
  always_comb begin
    arm_d      = arm_q | ~start;
    start_edge = start & ~start_q & arm_q;

    if (32'(score) >= LVL3_SCORE)      target = 2'd3;
    else if (32'(score) >= LVL2_SCORE) target = 2'd2;
    else if (32'(score) >= LVL1_SCORE) target = 2'd1;
    else                               target = 2'd0;

    state_d = state_q;
    level_d = level_q;
    time_d  = time_q;

    case (state_q)
      ST_PLAY: begin
        if (target > level_q) level_d = target;
        if (tick && time_q == 8'd1) begin
          time_d  = 8'd0;
          state_d = ST_OVER;
        end else if (stop) begin
          state_d = ST_OVER;
        end else if (tick) begin
          time_d = time_q - 8'd1;
        end
      end
      default: begin
        if (state_q == ST_IDLE) level_d = '0;
        if (start_edge) begin
          state_d = ST_PLAY;
          level_d = '0;
          time_d  = ROUND_T;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      arm_q   <= ~start;
      level_q <= '0;
      time_q  <= ROUND_T;
    end else begin
      state_q <= state_d;
      start_q <= start;
      arm_q   <= arm_d;
      level_q <= level_d;
      time_q  <= time_d;
    end
  end

  always_comb begin
    case (level_q)
      2'd0:    speed = SPD0;
      2'd1:    speed = SPD1;
      2'd2:    speed = SPD2;
      default: speed = SPD3;
    endcase
    game      = (state_q == ST_PLAY);
    game_over = (state_q == ST_OVER);
    level     = level_q;
    time_left = time_q;
  end

endmodule

// File: tb/tb_level_controller.sv
// tb/tb_level_controller.sv - randomized and directed bench for level_controller
module tb_level_controller;

  localparam int HZ  = 8;
  localparam int RND = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [7:0]  score = 8'd0;
  logic        game, game_over;
  logic [27:0] speed;
  logic [1:0]  level;
  logic [7:0]  time_left;

  int vectors = 0;
  int miscompares = 0;
  bit chk = 0;

  level_controller #(
    .CLK_HZ(HZ), .ROUND_SECONDS(RND),
    .LVL1_SCORE(10), .LVL2_SCORE(20), .LVL3_SCORE(30)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .score(score),
    .game(game), .speed(speed), .level(level), .time_left(time_left),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Model: 0 idle, 1 playing, 2 over. Time left is derived from the number
  // of edges spent in the round rather than from a countdown register.
  int m_state = 0;
  int m_level = 0;
  int m_time  = RND;
  int m_pc    = 0;
  bit m_prev  = 0;
  bit m_armed = 0;
  int spd_tab [4] = '{8, 6, 4, 2};

  always @(posedge clock) begin
    int tgt;
    bit edge_s;
    if (reset) begin
      m_state = 0; m_level = 0; m_time = RND; m_pc = 0;
      m_prev = 0; m_armed = !start;
    end else begin
      edge_s  = start && !m_prev && m_armed;
      m_armed = m_armed || !start;
      m_prev  = start;
      if (m_state == 1) begin
        tgt = (score >= 30) ? 3 : (score >= 20) ? 2 : (score >= 10) ? 1 : 0;
        if (tgt > m_level) m_level = tgt;
        m_pc++;
        if (m_pc == RND * HZ) begin
          m_time = 0; m_state = 2;
        end else if (stop) begin
          m_state = 2;
        end else begin
          m_time = RND - m_pc / HZ;
        end
      end else begin
        if (m_state == 0) m_level = 0;
        if (edge_s) begin
          m_state = 1; m_level = 0; m_time = RND; m_pc = 0;
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk) begin
      cmp("game", int'(game), int'(m_state == 1));
      cmp("game_over", int'(game_over), int'(m_state == 2));
      cmp("level", int'(level), m_level);
      cmp("speed", int'(speed), spd_tab[m_level]);
      cmp("time_left", int'(time_left), m_time);
    end
  end

  task automatic wn(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wn(1);
    start = 1'b0;
  endtask

  initial begin
    wn(3);
    reset = 1'b0;
    chk = 1;
    wn(20);
    cmp("lit_idle_game", int'(game), 0);
    cmp("lit_idle_level", int'(level), 0);
    cmp("lit_idle_speed", int'(speed), 8);
    cmp("lit_idle_time", int'(time_left), 3);
    cmp("lit_idle_over", int'(game_over), 0);

    // full round
    pulse_start();
    cmp("lit_start_game", int'(game), 1);
    cmp("lit_start_time", int'(time_left), 3);
    wn(8);
    cmp("lit_t8", int'(time_left), 2);
    wn(8);
    cmp("lit_t16", int'(time_left), 1);
    wn(7);
    cmp("lit_t23_game", int'(game), 1);
    wn(1);
    cmp("lit_end_game", int'(game), 0);
    cmp("lit_end_over", int'(game_over), 1);
    cmp("lit_end_time", int'(time_left), 0);

    // level climbing, never falling, multi-step jump
    wn(2);
    pulse_start();
    score = 8'd10; wn(1);
    cmp("lit_lvl1", int'(level), 1);
    cmp("lit_spd1", int'(speed), 6);
    score = 8'd25; wn(1);
    cmp("lit_lvl2", int'(level), 2);
    cmp("lit_spd2", int'(speed), 4);
    score = 8'd5; wn(1);
    cmp("lit_lvl_hold", int'(level), 2);
    cmp("lit_spd_hold", int'(speed), 4);
    score = 8'd0; wn(25);
    pulse_start();
    score = 8'd30; wn(1);
    cmp("lit_jump_lvl", int'(level), 3);
    cmp("lit_jump_spd", int'(speed), 2);
    score = 8'd0;

    // stop at the 11th edge of the round
    wn(25);
    pulse_start();
    wn(10);
    stop = 1'b1; wn(1); stop = 1'b0;
    cmp("lit_stop_over", int'(game_over), 1);
    cmp("lit_stop_time", int'(time_left), 2);
    wn(3);
    pulse_start();
    cmp("lit_restart_level", int'(level), 0);
    cmp("lit_restart_time", int'(time_left), 3);
    wn(7);
    cmp("lit_restart_t7", int'(time_left), 3);
    wn(1);
    cmp("lit_restart_t8", int'(time_left), 2);

    // reset mid-round with start held high
    wn(30);
    start = 1'b1; wn(1);
    cmp("lit_rs_game", int'(game), 1);
    wn(4);
    reset = 1'b1; wn(1); reset = 1'b0;
    cmp("lit_rs_idle", int'(game), 0);
    cmp("lit_rs_time", int'(time_left), 3);
    wn(6);
    cmp("lit_rs_held", int'(game), 0);
    start = 1'b0; wn(1);
    start = 1'b1; wn(1);
    cmp("lit_rs_fresh", int'(game), 1);
    start = 1'b0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) start = ~start;
      stop  = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) score = 8'($urandom_range(0, 40));
      wn(1);
    end
    reset = 1'b0; stop = 1'b0;
    wn(2);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
